// File: rtl/ipf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ipf_pkg
// Purpose  : Shared definitions for the IPF LCU feeder. Holds the image
//            geometry, the feeder FSM state encoding, the bit layout of a
//            parameter-memory word and the unpacked parameter bundle.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ipf_pkg;

  // Image geometry: square image tiled by square LCUs
  localparam int IMG_W   = 128;
  localparam int LCU_W   = 16;
  localparam int N_LCU_X = IMG_W / LCU_W;

  // Feeder FSM state encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PLOAD  = 3'd1;
  localparam logic [2:0] S_PCAP   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Field offsets inside a 24-bit parameter-memory word
  localparam int PAR_TYPE_LSB = 22;
  localparam int PAR_BAND_LSB = 17;
  localparam int PAR_WO_LSB   = 16;
  localparam int PAR_OFF_LSB  = 0;

  typedef struct packed {
    logic [1:0]  ptype;
    logic [4:0]  band_pos;
    logic        wo_class;
    logic [15:0] offset;
  } ipf_param_t;

  function automatic ipf_param_t unpack_param(input logic [23:0] raw);
    ipf_param_t p;
    p.ptype    = raw[PAR_TYPE_LSB +: 2];
    p.band_pos = raw[PAR_BAND_LSB +: 5];
    p.wo_class = raw[PAR_WO_LSB];
    p.offset   = raw[PAR_OFF_LSB +: 16];
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipf_skid1.sv
`default_nettype none
// ============================================================================
// Module   : ipf_skid1
// Purpose  : One-entry skid buffer for 8-bit pixel data. A push while empty
//            is visible on the output in the same cycle; if it is not popped
//            it is stored. A stored entry holds until popped. Push and pop
//            together while full replace the entry (pass-through).
// Ports    : clk     - clock, rising edge
//            reset   - asynchronous active-low reset
//            i_push  - new data available on i_data
//            i_data  - data to push
//            i_pop   - consumer takes o_data this cycle when o_valid
//            o_valid - o_data is valid (stored entry or bypassed push)
//            o_data  - oldest available data
//            o_full  - an entry is stored
// Revision : 1.0 - initial release
// ============================================================================
module ipf_skid1 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_full
);

  logic       r_valid;
  logic [7:0] r_data;

  assign o_valid = r_valid | i_push;
  assign o_data  = r_valid ? r_data : i_data;
  assign o_full  = r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= 8'd0;
    end else if (r_valid) begin
      if (i_pop) begin
        if (i_push) begin
          r_data <= i_data;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end else if (i_push && !i_pop) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ipf_lcu_feeder.sv
`default_nettype none
// ============================================================================
// Module   : ipf_lcu_feeder
// Purpose  : Reads a 128x128 8-bit image from pixel memory in LCU order
//            (16x16 blocks, raster within and between LCUs) and streams it to
//            the IPF filter one pixel per cycle, honouring busy back-pressure.
//            Drives the per-LCU filter controls from a 64-entry parameter
//            memory, prefetching the next LCU's entry while streaming.
// Ports    : clk, reset (async active-low), start (1-cycle pulse), busy
//            pix_addr/pix_re/pix_rdata : pixel memory, 1-cycle read latency
//            par_addr/par_re/par_rdata : parameter memory, 1-cycle latency
//            in_en/din                 : pixel stream to the filter
//            ipf_type/ipf_band_pos/ipf_wo_class/ipf_offset, lcu_x/lcu_y,
//            lcu_size                  : controls for the LCU being presented
//            frame_done                : 1-cycle pulse after the last pixel
// Revision : 1.0 - initial release
// ============================================================================
module ipf_lcu_feeder
  import ipf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        busy,
  output logic [13:0] pix_addr,
  input  logic [7:0]  pix_rdata,
  output logic        pix_re,
  output logic [5:0]  par_addr,
  input  logic [23:0] par_rdata,
  output logic        par_re,
  output logic        in_en,
  output logic [7:0]  din,
  output logic [1:0]  ipf_type,
  output logic [4:0]  ipf_band_pos,
  output logic        ipf_wo_class,
  output logic [15:0] ipf_offset,
  output logic [2:0]  lcu_x,
  output logic [2:0]  lcu_y,
  output logic [1:0]  lcu_size,
  output logic        frame_done
);

  localparam logic [13:0] c_LAST_PIX = 14'(IMG_W * IMG_W - 1);
  localparam logic [5:0]  c_LAST_LCU = 6'(N_LCU_X * N_LCU_X - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;

  logic        w_pload;
  logic        w_pcap;
  logic        w_stream_en;

  // Issue side counts reads sent to pixel memory; output side counts pixels
  // presented to the filter. Bits [13:8] are the LCU index, [7:0] the pixel.
  logic [13:0] r_iss_cnt;
  logic [13:0] r_out_cnt;
  logic        r_iss_done;
  logic        r_ret;

  logic        r_pf_req;
  logic        r_pf_cap;
  logic [5:0]  r_pf_addr;

  ipf_param_t  r_cur;
  ipf_param_t  r_next;
  ipf_param_t  w_ctl;
  logic [5:0]  r_cur_lcu;

  logic        w_issue;
  logic        w_iss_first;
  logic [5:0]  w_iss_lcu;
  logic [5:0]  w_out_lcu;
  logic        w_last_out;
  logic        w_in_en;
  logic        w_swap;
  logic        w_skid_valid;
  logic        w_skid_full;
  logic [7:0]  w_skid_data;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_PLOAD;
      S_PLOAD:  w_state_nxt = S_PCAP;
      S_PCAP:   w_state_nxt = S_STREAM;
      // Leave only once the final pixel has actually been presented
      S_STREAM: if (w_in_en && w_last_out) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_pload     = 1'b0;
    w_pcap      = 1'b0;
    w_stream_en = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      S_PLOAD:  w_pload = 1'b1;
      // Pixel 0 is issued while LCU 0's parameters are being captured so the
      // first pixel reaches the filter one cycle after the capture.
      S_PCAP: begin
        w_pcap      = 1'b1;
        w_stream_en = 1'b1;
      end
      S_STREAM: w_stream_en = 1'b1;
      S_DONE:   frame_done = 1'b1;
      default:  ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pixel read issue and addressing
  // --------------------------------------------------------------------------
  assign w_iss_lcu   = r_iss_cnt[13:8];
  assign w_iss_first = (r_iss_cnt[7:0] == 8'd0);

  // A stored skid entry must drain before any new read is issued
  assign w_issue  = w_stream_en & ~busy & ~w_skid_full & ~r_iss_done;
  assign pix_re   = w_issue;
  assign pix_addr = {w_iss_lcu[5:3], r_iss_cnt[7:4], w_iss_lcu[2:0], r_iss_cnt[3:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iss_cnt  <= 14'd0;
      r_out_cnt  <= 14'd0;
      r_iss_done <= 1'b0;
      r_ret      <= 1'b0;
      r_pf_req   <= 1'b0;
      r_pf_cap   <= 1'b0;
      r_pf_addr  <= 6'd0;
    end else begin
      if (w_pload) begin
        r_iss_cnt  <= 14'd0;
        r_out_cnt  <= 14'd0;
        r_iss_done <= 1'b0;
      end else begin
        if (w_issue) begin
          r_iss_cnt <= r_iss_cnt + 14'd1;
          if (r_iss_cnt == c_LAST_PIX) r_iss_done <= 1'b1;
        end
        if (w_in_en) r_out_cnt <= r_out_cnt + 14'd1;
      end
      r_ret <= w_issue;
      // Prefetch the next LCU's entry the cycle after its predecessor's
      // pixel 0 is issued; the parameter port is otherwise idle then.
      r_pf_req <= w_issue && w_iss_first && (w_iss_lcu != c_LAST_LCU);
      if (w_issue && w_iss_first) r_pf_addr <= w_iss_lcu + 6'd1;
      r_pf_cap <= r_pf_req;
    end
  end

  assign par_re   = w_pload | r_pf_req;
  assign par_addr = r_pf_req ? r_pf_addr : 6'd0;

  // --------------------------------------------------------------------------
  // Return path: every returned pixel goes through the skid, which bypasses
  // combinationally when the filter is not busy.
  // --------------------------------------------------------------------------
  ipf_skid1 u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_ret),
    .i_data  (pix_rdata),
    .i_pop   (~busy),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_full  (w_skid_full)
  );

  assign w_in_en    = w_skid_valid & ~busy;
  assign w_last_out = (r_out_cnt == c_LAST_PIX);
  assign in_en      = w_in_en;
  assign din        = w_in_en ? w_skid_data : 8'd0;

  // --------------------------------------------------------------------------
  // Per-LCU controls. The presented pixel 0 of LCU k>0 selects the prefetched
  // entry directly so controls change in the same cycle as that pixel; the
  // entry becomes current at the end of that cycle.
  // --------------------------------------------------------------------------
  assign w_out_lcu = r_out_cnt[13:8];
  assign w_swap    = w_in_en && (r_out_cnt[7:0] == 8'd0) && (w_out_lcu != 6'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur     <= '0;
      r_next    <= '0;
      r_cur_lcu <= 6'd0;
    end else begin
      if (w_pcap) begin
        r_cur     <= unpack_param(par_rdata);
        r_cur_lcu <= 6'd0;
      end else if (w_swap) begin
        r_cur     <= r_next;
        r_cur_lcu <= w_out_lcu;
      end
      if (r_pf_cap) r_next <= unpack_param(par_rdata);
    end
  end

  assign w_ctl        = w_swap ? r_next : r_cur;
  assign ipf_type     = w_ctl.ptype;
  assign ipf_band_pos = w_ctl.band_pos;
  assign ipf_wo_class = w_ctl.wo_class;
  assign ipf_offset   = w_ctl.offset;
  assign lcu_x        = w_swap ? w_out_lcu[2:0] : r_cur_lcu[2:0];
  assign lcu_y        = w_swap ? w_out_lcu[5:3] : r_cur_lcu[5:3];
  assign lcu_size     = 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_ipf_lcu_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipf_lcu_feeder
// Purpose  : Directed self-checking bench for ipf_lcu_feeder. Pixel memory
//            returns addr[7:0]; parameter entry k is
//            {k[3:2], k[4:0], k[0], 16'(k)}. Frames are run free, with
//            periodic busy, with long and boundary stalls, and across a
//            mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipf_lcu_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy = 1'b0;
  logic [13:0] pix_addr;
  logic [7:0]  pix_rdata = 8'd0;
  logic        pix_re;
  logic [5:0]  par_addr;
  logic [23:0] par_rdata = 24'd0;
  logic        par_re;
  logic        in_en;
  logic [7:0]  din;
  logic [1:0]  ipf_type;
  logic [4:0]  ipf_band_pos;
  logic        ipf_wo_class;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x;
  logic [2:0]  lcu_y;
  logic [1:0]  lcu_size;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ipf_lcu_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .pix_addr     (pix_addr),
    .pix_rdata    (pix_rdata),
    .pix_re       (pix_re),
    .par_addr     (par_addr),
    .par_rdata    (par_rdata),
    .par_re       (par_re),
    .in_en        (in_en),
    .din          (din),
    .ipf_type     (ipf_type),
    .ipf_band_pos (ipf_band_pos),
    .ipf_wo_class (ipf_wo_class),
    .ipf_offset   (ipf_offset),
    .lcu_x        (lcu_x),
    .lcu_y        (lcu_y),
    .lcu_size     (lcu_size),
    .frame_done   (frame_done)
  );

  // Memory models, 1-cycle read latency
  always @(posedge clk) begin
    if (pix_re) pix_rdata <= pix_addr[7:0];
    if (par_re) par_rdata <= {par_addr[3:2], par_addr[4:0], par_addr[0], 10'd0, par_addr};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Address of the n-th pixel in LCU streaming order
  function automatic logic [13:0] exp_addr(input int n);
    int k, p, lx, ly, row, col;
    k   = n / 256;
    p   = n % 256;
    ly  = k / 8;
    lx  = k % 8;
    row = p / 16;
    col = p % 16;
    return 14'(((ly * 16 + row) << 7) + lx * 16 + col);
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_in_en"},      in_en,        0);
    check({pfx, "_din"},        din,          0);
    check({pfx, "_pix_re"},     pix_re,       0);
    check({pfx, "_pix_addr"},   pix_addr,     0);
    check({pfx, "_par_re"},     par_re,       0);
    check({pfx, "_par_addr"},   par_addr,     0);
    check({pfx, "_type"},       ipf_type,     0);
    check({pfx, "_band"},       ipf_band_pos, 0);
    check({pfx, "_wo"},         ipf_wo_class, 0);
    check({pfx, "_offset"},     ipf_offset,   0);
    check({pfx, "_lcu_x"},      lcu_x,        0);
    check({pfx, "_lcu_y"},      lcu_y,        0);
    check({pfx, "_lcu_size"},   lcu_size,     0);
    check({pfx, "_frame_done"}, frame_done,   0);
  endtask

  // mode 0: busy=0 throughout, latency checks
  // mode 1: busy high every 3rd cycle for the first 3000 cycles, extra start
  // mode 2: 10-cycle stall after an issue, 3-cycle stall on LCU 7 pixel 255
  // stop_at >= 0: return after that many pixels have been presented
  task automatic run_frame(input int mode, input int stop_at);
    int          cyc = 0;
    int          n_exp = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          bsy_left = 0;
    bit          fin = 1'b0;
    logic [13:0] ea;
    logic [13:0] a2047;
    logic [5:0]  kk;
    a2047 = exp_addr(2047);
    while (!fin && cyc < 40000) begin
      @(negedge clk);
      start = (cyc == 0) || (mode == 1 && cyc == 500);
      case (mode)
        1: busy = (cyc < 3000) && (cyc % 3 == 2);
        2: begin
          if (cyc >= 100 && cyc < 110) busy = 1'b1;
          else if (bsy_left > 0) begin
            busy = 1'b1;
            bsy_left--;
          end else busy = 1'b0;
        end
        default: busy = 1'b0;
      endcase
      #1;
      if (busy) check("pix_re_while_busy", pix_re, 0);
      if (mode == 0) begin
        case (cyc)
          1: begin
            check("lat_par_re", par_re, 1);
            check("lat_par_addr", par_addr, 0);
            check("lat_pix_re_early", pix_re, 0);
            check("lcu_size", lcu_size, 0);
          end
          2: begin
            check("lat_pix_re", pix_re, 1);
            check("lat_pix_addr", pix_addr, 0);
            check("lat_in_en_early", in_en, 0);
          end
          3: check("lat_in_en", in_en, 1);
          default: ;
        endcase
      end
      if (mode == 2) begin
        if (cyc == 105) begin
          check("stall_in_en", in_en, 0);
          check("stall_pix_re", pix_re, 0);
        end
        if (cyc == 110) begin
          ea = exp_addr(97);
          check("skid_first_en", in_en, 1);
          check("skid_first_din", din, {24'd0, ea[7:0]});
          check("skid_first_idx", n_exp, 97);
          check("skid_drain_no_issue", pix_re, 0);
        end
        if (cyc == 111) begin
          check("post_skid_pix_re", pix_re, 1);
          check("post_skid_addr", pix_addr, exp_addr(98));
        end
        if (pix_re && pix_addr == a2047) bsy_left = 3;
      end
      if (in_en) begin
        ea = exp_addr(n_exp);
        check("din", din, {24'd0, ea[7:0]});
        if (n_exp % 256 == 0 || n_exp % 256 == 255) begin
          kk = 6'(n_exp / 256);
          check("lcu_x", lcu_x, kk[2:0]);
          check("lcu_y", lcu_y, kk[5:3]);
          check("ipf_offset", ipf_offset, kk);
          check("ipf_type", ipf_type, kk[3:2]);
          check("ipf_band_pos", ipf_band_pos, kk[4:0]);
          check("ipf_wo_class", ipf_wo_class, kk[0]);
        end
        n_exp++;
        if (stop_at >= 0 && n_exp == stop_at) fin = 1'b1;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("pixels_at_done", n_exp, 16384);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) begin
        check("hold_offset", ipf_offset, 63);
        check("hold_type", ipf_type, 3);
        check("hold_lcu_x", lcu_x, 7);
        check("hold_lcu_y", lcu_y, 7);
        check("idle_in_en", in_en, 0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) fin = 1'b1;
      cyc++;
    end
    start = 1'b0;
    busy  = 1'b0;
    if (stop_at >= 0) begin
      check("partial_pixels", n_exp, stop_at);
    end else begin
      check("frame_done_count", done_cnt, 1);
      check("pixels_total", n_exp, 16384);
      if (mode == 0) check("done_cycle", done_cyc, 16387);
    end
  endtask

  initial begin
    @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(0, 20 * 256 + 100);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_frame(2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
